// File: rtl/morse_tx.sv
// Morse code transmitter: one character per valid/ready handshake, keyed out with ITU unit timing.
// Optional sidetone on tone_out is enabled by defining MORSE_TX_TONE_EN.
module morse_tx #(
  parameter int CLK_FREQ = 100_000,
  parameter int UNIT_MS  = 100,
  parameter int TONE_HZ  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [5:0] char_code,
  output logic       char_ready,
  output logic       busy,
  output logic       key_out,
  output logic       err,
  output logic       tone_out
);

  localparam int UNIT_CYC = (CLK_FREQ / 1000) * UNIT_MS;
  localparam int CNT_W    = $clog2(7 * UNIT_CYC + 1);

  localparam logic [CNT_W-1:0] LOAD_1U = CNT_W'(UNIT_CYC - 1);
  localparam logic [CNT_W-1:0] LOAD_3U = CNT_W'(3 * UNIT_CYC - 1);
  localparam logic [CNT_W-1:0] LOAD_4U = CNT_W'(4 * UNIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MARK     = 3'd1,
    GAP      = 3'd2,
    CHAR_GAP = 3'd3,
    WORD_GAP = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0]       code_q, code_d;
  logic             err_d;
  logic             take;
  logic [7:0]       pat, first_pat;
  logic [2:0]       pat_len;
  logic [4:0]       pat_bits;

  // Pattern entry: {length[2:0], elements[4:0]} with elements left-aligned, 1 = dash.
  function automatic logic [7:0] rom(input logic [5:0] code);
    case (code)
      6'd0:  rom = {3'd2, 5'b01000};  // A
      6'd1:  rom = {3'd4, 5'b10000};  // B
      6'd2:  rom = {3'd4, 5'b10100};  // C
      6'd3:  rom = {3'd3, 5'b10000};  // D
      6'd4:  rom = {3'd1, 5'b00000};  // E
      6'd5:  rom = {3'd4, 5'b00100};  // F
      6'd6:  rom = {3'd3, 5'b11000};  // G
      6'd7:  rom = {3'd4, 5'b00000};  // H
      6'd8:  rom = {3'd2, 5'b00000};  // I
      6'd9:  rom = {3'd4, 5'b01110};  // J
      6'd10: rom = {3'd3, 5'b10100};  // K
      6'd11: rom = {3'd4, 5'b01000};  // L
      6'd12: rom = {3'd2, 5'b11000};  // M
      6'd13: rom = {3'd2, 5'b10000};  // N
      6'd14: rom = {3'd3, 5'b11100};  // O
      6'd15: rom = {3'd4, 5'b01100};  // P
      6'd16: rom = {3'd4, 5'b11010};  // Q
      6'd17: rom = {3'd3, 5'b01000};  // R
      6'd18: rom = {3'd3, 5'b00000};  // S
      6'd19: rom = {3'd1, 5'b10000};  // T
      6'd20: rom = {3'd3, 5'b00100};  // U
      6'd21: rom = {3'd4, 5'b00010};  // V
      6'd22: rom = {3'd3, 5'b01100};  // W
      6'd23: rom = {3'd4, 5'b10010};  // X
      6'd24: rom = {3'd4, 5'b10110};  // Y
      6'd25: rom = {3'd4, 5'b11000};  // Z
      6'd26: rom = {3'd5, 5'b11111};  // 0
      6'd27: rom = {3'd5, 5'b01111};  // 1
      6'd28: rom = {3'd5, 5'b00111};  // 2
      6'd29: rom = {3'd5, 5'b00011};  // 3
      6'd30: rom = {3'd5, 5'b00001};  // 4
      6'd31: rom = {3'd5, 5'b00000};  // 5
      6'd32: rom = {3'd5, 5'b10000};  // 6
      6'd33: rom = {3'd5, 5'b11000};  // 7
      6'd34: rom = {3'd5, 5'b11100};  // 8
      6'd35: rom = {3'd5, 5'b11110};  // 9
      default: rom = {3'd1, 5'b00000};
    endcase
  endfunction

  assign pat       = rom(code_q);
  assign first_pat = rom(char_code);
  assign pat_len   = pat[7:5];
  assign pat_bits  = pat[4:0];

  // Handshake: a character transfers on a rising edge where char_valid is high and the
  // block is idle, or where the closing gap of the previous character is on its last
  // cycle, so back-to-back characters are separated by exactly the 3U character gap.
  assign take = char_valid &&
                ((state_q == IDLE) ||
                 (((state_q == CHAR_GAP) || (state_q == WORD_GAP)) && (cnt_q == '0)));

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    idx_d   = idx_q;
    code_d  = code_q;
    err_d   = 1'b0;

    case (state_q)
      MARK: begin
        if (cnt_q == '0) begin
          if (idx_q + 3'd1 == pat_len) begin
            state_d = CHAR_GAP;
            cnt_d   = LOAD_3U;
          end else begin
            state_d = GAP;
            cnt_d   = LOAD_1U;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = MARK;
          cnt_d   = pat_bits[3'd4 - idx_q] ? LOAD_3U : LOAD_1U;
        end
      end
      CHAR_GAP, WORD_GAP: begin
        if (cnt_q == '0) state_d = IDLE;
      end
      default: ;
    endcase

    if (take) begin
      if (char_code <= 6'd35) begin
        state_d = MARK;
        code_d  = char_code;
        idx_d   = 3'd0;
        cnt_d   = first_pat[4] ? LOAD_3U : LOAD_1U;
      end else if (char_code == 6'd36) begin
        state_d = WORD_GAP;
        cnt_d   = LOAD_4U;
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      code_q     <= 6'd0;
      err        <= 1'b0;
      key_out    <= 1'b0;
      char_ready <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      err        <= err_d;
      key_out    <= (state_d == MARK);
      char_ready <= (state_d == IDLE);
    end
  end

  assign busy = ~char_ready;

`ifdef MORSE_TX_TONE_EN
  localparam int TONE_HALF_RAW = CLK_FREQ / (2 * TONE_HZ);
  localparam int TONE_HALF     = (TONE_HALF_RAW < 1) ? 1 : TONE_HALF_RAW;
  localparam int TONE_W        = $clog2(TONE_HALF + 1);

  logic [TONE_W-1:0] tone_cnt_q;
  logic              tone_q;

  // Phase restarts high on every mark entry so each element starts with the same waveform.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (state_d != MARK) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (state_q != MARK) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b1;
    end else if (tone_cnt_q == TONE_W'(TONE_HALF - 1)) begin
      tone_cnt_q <= '0;
      tone_q     <= ~tone_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + 1'b1;
    end
  end

  assign tone_out = tone_q;
`else
  assign tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx with U = 2 cycles; sidetone period checked when MORSE_TX_TONE_EN is defined.
module tb_morse_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       char_valid;
  logic [5:0] char_code;
  logic       char_ready;
  logic       busy;
  logic       key_out;
  logic       err;
  logic       tone_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  morse_tx #(
    .CLK_FREQ (1000),
    .UNIT_MS  (2),
    .TONE_HZ  (250)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_ready (char_ready),
    .busy       (busy),
    .key_out    (key_out),
    .err        (err),
    .tone_out   (tone_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
  endtask

  // Present a code for one acceptance edge; returns at the first sample after acceptance.
  task automatic send(input logic [5:0] code);
    @(negedge clk);
    char_valid = 1'b1;
    char_code  = code;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  // Expect key_out == v for n consecutive cycles; a mark sample j also predicts the sidetone.
  task automatic expect_key(input logic v, input int n, input string tag);
    logic exp_tone;
    for (int j = 0; j < n; j++) begin
      check({tag, "_key"}, key_out, v);
`ifdef MORSE_TX_TONE_EN
      exp_tone = v && (((j / 2) % 2) == 0);
`else
      exp_tone = 1'b0;
`endif
      check({tag, "_tone"}, tone_out, exp_tone);
      check({tag, "_busy"}, busy, 1'b1);
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    char_valid = 1'b0;
    char_code  = 6'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", char_ready, 1'b1);
    check("rst_busy",  busy,       1'b0);
    check("rst_key",   key_out,    1'b0);
    check("rst_err",   err,        1'b0);
    check("rst_tone",  tone_out,   1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 'E': dot then character gap, 8 cycles busy
    send(6'd4);
    expect_key(1'b1, 2, "e_mark");
    expect_key(1'b0, 6, "e_cgap");
    check("e_ready", char_ready, 1'b1);
    check("e_err",   err,        1'b0);

    // 'A': dot, gap, dash, character gap
    send(6'd0);
    expect_key(1'b1, 2, "a_dot");
    expect_key(1'b0, 2, "a_gap");
    expect_key(1'b1, 6, "a_dash");
    expect_key(1'b0, 6, "a_cgap");
    check("a_ready", char_ready, 1'b1);

    // '0': five dashes; a stray valid pulse inside a gap must be ignored
    send(6'd26);
    expect_key(1'b1, 6, "d0_m0");
    char_valid = 1'b1;
    char_code  = 6'd4;
    expect_key(1'b0, 1, "d0_g0a");
    char_valid = 1'b0;
    expect_key(1'b0, 1, "d0_g0b");
    for (int i = 0; i < 3; i++) begin
      expect_key(1'b1, 6, "d0_m");
      expect_key(1'b0, 2, "d0_g");
    end
    expect_key(1'b1, 6, "d0_m4");
    expect_key(1'b0, 6, "d0_cgap");
    check("d0_ready", char_ready, 1'b1);
    repeat (4) begin
      check("d0_noqueue_key", key_out, 1'b0);
      check("d0_noqueue_rdy", char_ready, 1'b1);
      @(negedge clk);
    end

    // Space then 'T' with char_valid held: T chains on the last word-gap edge
    @(negedge clk);
    char_valid = 1'b1;
    char_code  = 6'd36;
    @(negedge clk);
    char_code  = 6'd19;
    expect_key(1'b0, 8, "sp_wgap");
    char_valid = 1'b0;
    check("t_chain_ready", char_ready, 1'b0);
    expect_key(1'b1, 6, "t_dash");
    expect_key(1'b0, 6, "t_cgap");
    check("t_ready", char_ready, 1'b1);

    // Invalid code: one-cycle err, never busy
    send(6'd40);
    check("inv_err1",   err,        1'b1);
    check("inv_ready1", char_ready, 1'b1);
    check("inv_key1",   key_out,    1'b0);
    @(negedge clk);
    check("inv_err2",   err,        1'b0);
    check("inv_ready2", char_ready, 1'b1);
    check("inv_key2",   key_out,    1'b0);

    // Reset in the middle of the first dash of 'O' acts without a clock edge
    send(6'd14);
    expect_key(1'b1, 3, "o_dash");
    #2 rst = 1'b1;
    #1;
    check("o_rst_key",   key_out,    1'b0);
    check("o_rst_tone",  tone_out,   1'b0);
    check("o_rst_ready", char_ready, 1'b1);
    check("o_rst_busy",  busy,       1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("o_post_key", key_out, 1'b0);
    send(6'd4);
    expect_key(1'b1, 2, "e2_mark");
    expect_key(1'b0, 6, "e2_cgap");
    check("e2_ready", char_ready, 1'b1);
    check("e2_err",   err,        1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
